// File: rtl/pipeline_debug_ctrl_pkg.sv
// Shared definitions for the pipeline debug sequencer: host command
// encodings, sequencer states and small state-decode helpers.
package pipeline_debug_ctrl_pkg;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_HALT  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_END  = 2'b11
    } state_e;

    // The pipeline is frozen whenever the sequencer is not executing.
    function automatic logic stateStops(input state_e s);
        return (s == ST_IDLE) || (s == ST_END);
    endfunction

    function automatic logic stateBusy(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_debug_ctrl_step_down_counter.sv
// Step budget counter: loaded on STEP acceptance, counts down once per
// stepped cycle and flags the final cycle of the step.
module step_down_counter #(
    parameter int STEP_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [STEP_W-1:0] load_val_i,
    input  logic              en_i,
    output logic              is_one_o
);

    logic [STEP_W-1:0] count_q;

    // Load takes priority; decrement stops at zero so the counter never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - STEP_W'(1);
        end
    end

    assign is_one_o = (count_q == STEP_W'(1));

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Run/step/halt sequencer driving the shared stop_debug freeze line of the
// 5-stage pipeline, with an executed-cycle counter and end-of-program latch.
module pipeline_debug_ctrl
    import pipeline_debug_ctrl_pkg::*;
#(
    parameter int STEP_W = 16,
    parameter int CYC_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    input  logic [1:0]        cmd_op_i,
    input  logic [STEP_W-1:0] cmd_count_i,
    output logic              cmd_ready_o,
    input  logic              halt_retired_i,
    output logic              stop_debug_o,
    output logic              busy_o,
    output logic              step_done_o,
    output logic              prog_end_o,
    output logic              cmd_err_o,
    output logic [CYC_W-1:0]  cycle_count_o
);

    state_e            state_q, state_d;
    logic              stop_q, busy_q, stepDone_q, progEnd_q, cmdErr_q;
    logic              stepDone_d, progEnd_d, cmdErr_d;
    logic [CYC_W-1:0]  cycleCount_q, cycleCount_d;
    logic              cmdAccept, stepLoad, stepIsOne, cycleClear;
    logic [STEP_W-1:0] stepLoadVal;

    // Commands are always accepted once out of reset; illegal ones are dropped with cmd_err.
    assign cmd_ready_o = rst_ni;
    assign cmdAccept   = cmd_valid_i & cmd_ready_o;

    // A zero step count still steps one cycle.
    assign stepLoad    = cmdAccept && (state_q == ST_IDLE) && (cmd_op_i == OP_STEP);
    assign stepLoadVal = (cmd_count_i == '0) ? STEP_W'(1) : cmd_count_i;
    assign cycleClear  = cmdAccept && (cmd_op_i == OP_CLEAR) &&
                         ((state_q == ST_IDLE) || (state_q == ST_END));

    step_down_counter #(
        .STEP_W (STEP_W)
    ) u_step_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (stepLoad),
        .load_val_i (stepLoadVal),
        .en_i       (state_q == ST_STEP),
        .is_one_o   (stepIsOne)
    );

    // Next-state decode; a retiring HALT instruction outranks any command or final step.
    always_comb begin
        state_d    = state_q;
        stepDone_d = 1'b0;
        cmdErr_d   = 1'b0;
        progEnd_d  = progEnd_q;
        case (state_q)
            ST_IDLE: begin
                if (cmdAccept) begin
                    if (cmd_op_i == OP_RUN) begin
                        state_d = ST_RUN;
                    end else if (cmd_op_i == OP_STEP) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                if (halt_retired_i) begin
                    state_d   = ST_END;
                    progEnd_d = 1'b1;
                end else if (cmdAccept) begin
                    if (cmd_op_i == OP_HALT) begin
                        state_d = ST_IDLE;
                    end else begin
                        cmdErr_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (halt_retired_i) begin
                    state_d   = ST_END;
                    progEnd_d = 1'b1;
                end else if (cmdAccept && (cmd_op_i == OP_HALT)) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cmdAccept) begin
                        cmdErr_d = 1'b1;
                    end
                    if (stepIsOne) begin
                        state_d    = ST_IDLE;
                        stepDone_d = 1'b1;
                    end
                end
            end
            ST_END: begin
                if (cmdAccept) begin
                    if (cmd_op_i == OP_CLEAR) begin
                        state_d   = ST_IDLE;
                        progEnd_d = 1'b0;
                    end else if (cmd_op_i != OP_HALT) begin
                        cmdErr_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer register; outputs are decoded from the next state so stop_debug only moves at posedge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            stop_q     <= 1'b1;
            busy_q     <= 1'b0;
            stepDone_q <= 1'b0;
            progEnd_q  <= 1'b0;
            cmdErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stateStops(state_d);
            busy_q     <= stateBusy(state_d);
            stepDone_q <= stepDone_d;
            progEnd_q  <= progEnd_d;
            cmdErr_q   <= cmdErr_d;
        end
    end

    // Executed cycles are those where the registered freeze line was low; the count saturates.
    always_comb begin
        cycleCount_d = cycleCount_q;
        if (cycleClear) begin
            cycleCount_d = '0;
        end else if (!stop_q && (cycleCount_q != '1)) begin
            cycleCount_d = cycleCount_q + CYC_W'(1);
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycleCount_q <= '0;
        end else begin
            cycleCount_q <= cycleCount_d;
        end
    end

    assign stop_debug_o  = stop_q;
    assign busy_o        = busy_q;
    assign step_done_o   = stepDone_q;
    assign prog_end_o    = progEnd_q;
    assign cmd_err_o     = cmdErr_q;
    assign cycle_count_o = cycleCount_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: a default-width instance plus a
// 4-bit cycle counter instance sharing the same stimulus.
module tb_pipeline_debug_ctrl;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_HALT  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic        clk;
    logic        rstN;
    logic        cmdValid;
    logic [1:0]  cmdOp;
    logic [15:0] cmdCount;
    logic        haltRetired;

    logic        cmdReady, stopDebug, busy, stepDone, progEnd, cmdErr;
    logic [31:0] cycleCount;
    logic        smallReady, smallStop, smallBusy, smallDone, smallEnd, smallErr;
    logic [3:0]  smallCount;

    int vecCount = 0;
    int errCount = 0;

    pipeline_debug_ctrl #(.STEP_W(16), .CYC_W(32)) u_dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .cmd_valid_i    (cmdValid),
        .cmd_op_i       (cmdOp),
        .cmd_count_i    (cmdCount),
        .cmd_ready_o    (cmdReady),
        .halt_retired_i (haltRetired),
        .stop_debug_o   (stopDebug),
        .busy_o         (busy),
        .step_done_o    (stepDone),
        .prog_end_o     (progEnd),
        .cmd_err_o      (cmdErr),
        .cycle_count_o  (cycleCount)
    );

    pipeline_debug_ctrl #(.STEP_W(16), .CYC_W(4)) u_small (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .cmd_valid_i    (cmdValid),
        .cmd_op_i       (cmdOp),
        .cmd_count_i    (cmdCount),
        .cmd_ready_o    (smallReady),
        .halt_retired_i (haltRetired),
        .stop_debug_o   (smallStop),
        .busy_o         (smallBusy),
        .step_done_o    (smallDone),
        .prog_end_o     (smallEnd),
        .cmd_err_o      (smallErr),
        .cycle_count_o  (smallCount)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] count);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdCount = count;
        tick();
        cmdValid = 1'b0;
        cmdOp    = OP_RUN;
        cmdCount = '0;
    endtask

    initial begin
        rstN        = 1'b0;
        cmdValid    = 1'b0;
        cmdOp       = OP_RUN;
        cmdCount    = '0;
        haltRetired = 1'b0;

        #12;
        checkOutput("rst_ready", cmdReady, 1'b0);
        checkOutput("rst_stop", stopDebug, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_count", cycleCount, 0);
        checkOutput("rst_progend", progEnd, 1'b0);
        rstN = 1'b1;
        tick();
        checkOutput("idle_ready", cmdReady, 1'b1);
        checkOutput("idle_stop", stopDebug, 1'b1);

        // STEP 3: three unfrozen cycles, done pulse on the third edge after acceptance
        applyStimulus(OP_STEP, 16'd3);
        checkOutput("step3_c1_stop", stopDebug, 1'b0);
        checkOutput("step3_c1_busy", busy, 1'b1);
        for (int i = 2; i <= 3; i++) begin
            tick();
            checkOutput("step3_run_stop", stopDebug, 1'b0);
            checkOutput("step3_run_done", stepDone, 1'b0);
        end
        tick();
        checkOutput("step3_end_stop", stopDebug, 1'b1);
        checkOutput("step3_done", stepDone, 1'b1);
        checkOutput("step3_busy", busy, 1'b0);
        checkOutput("step3_count", cycleCount, 3);
        tick();
        checkOutput("step3_done_pulse", stepDone, 1'b0);

        // STEP 0 behaves as STEP 1
        applyStimulus(OP_STEP, 16'd0);
        checkOutput("step0_stop", stopDebug, 1'b0);
        tick();
        checkOutput("step0_end_stop", stopDebug, 1'b1);
        checkOutput("step0_done", stepDone, 1'b1);
        checkOutput("step0_count", cycleCount, 4);

        // RUN, illegal STEP mid-run, HALT after ten cycles
        applyStimulus(OP_RUN, 16'd0);
        checkOutput("run_stop", stopDebug, 1'b0);
        checkOutput("run_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(OP_STEP, 16'd5);
        checkOutput("run_step_err", cmdErr, 1'b1);
        checkOutput("run_step_stop", stopDebug, 1'b0);
        tick();
        checkOutput("run_err_pulse", cmdErr, 1'b0);
        checkOutput("run_still_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(OP_HALT, 16'd0);
        checkOutput("halt_stop", stopDebug, 1'b1);
        checkOutput("halt_busy", busy, 1'b0);
        checkOutput("halt_count", cycleCount, 14);

        // Illegal RUN during STEP: error pulse, step still completes on time
        applyStimulus(OP_STEP, 16'd3);
        applyStimulus(OP_RUN, 16'd0);
        checkOutput("stepcmd_err", cmdErr, 1'b1);
        checkOutput("stepcmd_stop", stopDebug, 1'b0);
        tick();
        checkOutput("stepcmd_stop2", stopDebug, 1'b0);
        tick();
        checkOutput("stepcmd_done", stepDone, 1'b1);
        checkOutput("stepcmd_count", cycleCount, 17);

        // HALT aborts a STEP without step_done
        applyStimulus(OP_STEP, 16'd4);
        tick();
        applyStimulus(OP_HALT, 16'd0);
        checkOutput("abort_stop", stopDebug, 1'b1);
        checkOutput("abort_done", stepDone, 1'b0);
        checkOutput("abort_count", cycleCount, 19);

        // CLEAR in IDLE, then long RUN to exercise saturation of the 4-bit counter
        applyStimulus(OP_CLEAR, 16'd0);
        checkOutput("clear_count", cycleCount, 0);
        checkOutput("clear_small", smallCount, 0);
        applyStimulus(OP_RUN, 16'd0);
        for (int i = 1; i <= 57; i++) begin
            tick();
            if (i == 15) checkOutput("sat_small_15", smallCount, 15);
            if (i == 20) begin
                checkOutput("sat_big_20", cycleCount, 20);
                checkOutput("sat_small_20", smallCount, 15);
            end
        end
        checkOutput("run57_count", cycleCount, 57);

        // Asynchronous reset mid-run, away from any clock edge
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arst_stop", stopDebug, 1'b1);
        checkOutput("arst_count", cycleCount, 0);
        checkOutput("arst_progend", progEnd, 1'b0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_ready", cmdReady, 1'b0);
        #1;
        rstN = 1'b1;
        tick();

        // RUN, HALT instruction retires on cycle 20
        applyStimulus(OP_RUN, 16'd0);
        for (int i = 0; i < 19; i++) tick();
        haltRetired = 1'b1;
        tick();
        haltRetired = 1'b0;
        checkOutput("end_stop", stopDebug, 1'b1);
        checkOutput("end_progend", progEnd, 1'b1);
        checkOutput("end_busy", busy, 1'b0);
        checkOutput("end_count", cycleCount, 20);
        checkOutput("end_small", smallCount, 15);
        applyStimulus(OP_RUN, 16'd0);
        checkOutput("end_run_err", cmdErr, 1'b1);
        checkOutput("end_run_stop", stopDebug, 1'b1);
        applyStimulus(OP_HALT, 16'd0);
        checkOutput("end_halt_noerr", cmdErr, 1'b0);
        checkOutput("end_halt_progend", progEnd, 1'b1);
        applyStimulus(OP_CLEAR, 16'd0);
        checkOutput("end_clear_progend", progEnd, 1'b0);
        checkOutput("end_clear_count", cycleCount, 0);
        checkOutput("end_clear_stop", stopDebug, 1'b1);

        // HALT instruction retires on the final cycle of a STEP 5
        applyStimulus(OP_STEP, 16'd5);
        for (int i = 0; i < 4; i++) tick();
        haltRetired = 1'b1;
        tick();
        haltRetired = 1'b0;
        checkOutput("stephalt_stop", stopDebug, 1'b1);
        checkOutput("stephalt_progend", progEnd, 1'b1);
        checkOutput("stephalt_done", stepDone, 1'b0);
        checkOutput("stephalt_count", cycleCount, 5);
        tick();
        checkOutput("stephalt_done2", stepDone, 1'b0);
        applyStimulus(OP_CLEAR, 16'd0);

        // HALT command on the same edge as a retiring HALT instruction
        applyStimulus(OP_RUN, 16'd0);
        tick();
        tick();
        haltRetired = 1'b1;
        applyStimulus(OP_HALT, 16'd0);
        haltRetired = 1'b0;
        checkOutput("tie_progend", progEnd, 1'b1);
        checkOutput("tie_err", cmdErr, 1'b0);
        checkOutput("tie_stop", stopDebug, 1'b1);
        checkOutput("tie_count", cycleCount, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
